// File: rtl/cc4_frame_sequencer_if.sv
// Bundle of payload, encoder, symbol-tag and noise-control signals that
// connect the frame sequencer to its encoder and surrounding logic.
// The master side is the sequencer; the slave side is its environment.
interface cc4_frame_sequencer_if #(
   parameter int CNT_W = 8
) ();
   logic             s_valid;
   logic             s_data;
   logic             s_ready;
   logic             enc_in;
   logic             enc_out1;
   logic             enc_out2;
   logic             m_valid;
   logic             m_out1;
   logic             m_out2;
   logic             m_sof;
   logic             m_eof;
   logic             m_tail;
   logic             m_abort;
   logic             noise_req;
   logic             noise_sel_req;
   logic             noise0;
   logic             noise1;
   logic             busy;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] err_cnt;

   modport master (
      input  s_valid, s_data, enc_out1, enc_out2, noise_req, noise_sel_req,
      output s_ready, enc_in, m_valid, m_out1, m_out2, m_sof, m_eof, m_tail,
             m_abort, noise0, noise1, busy, frame_cnt, err_cnt
   );

   modport slave (
      output s_valid, s_data, enc_out1, enc_out2, noise_req, noise_sel_req,
      input  s_ready, enc_in, m_valid, m_out1, m_out2, m_sof, m_eof, m_tail,
             m_abort, noise0, noise1, busy, frame_cnt, err_cnt
   );
endinterface

// File: rtl/cc4_frame_sequencer.sv
// Frame sequencer for the free-running K=4 rate-1/2 convolutional encoder.
// Feeds payload bits into the encoder, appends zero tail bits so the trellis
// terminates, tags the resulting symbol pairs and gates noise injection so
// errors only land on payload symbols with a minimum spacing between them.
module cc4_frame_sequencer #(
   parameter int FRAME_LEN = 16,
   parameter int TAIL_LEN  = 3,
   parameter int MIN_GAP   = 8,
   parameter int CNT_W     = 8
) (
   input logic                   clock,
   input logic                   reset,
   cc4_frame_sequencer_if.master bus
);
   localparam int BIT_W = $clog2(FRAME_LEN + TAIL_LEN + 1) + 1;
   localparam int GAP_W = $clog2(MIN_GAP + 1);

   localparam logic [BIT_W-1:0] PAY_LAST   = BIT_W'(FRAME_LEN - 1);
   localparam logic [BIT_W-1:0] TAIL_LAST  = BIT_W'(TAIL_LEN - 1);
   localparam logic [BIT_W-1:0] FLUSH_LAST = BIT_W'(TAIL_LEN);

   typedef enum logic [1:0] {FLUSH, IDLE, PAYLOAD, TAIL} state_t;

   state_t           state;
   state_t           state_next;
   logic [BIT_W-1:0] cnt;
   logic             abort;
   logic             s_ready;
   logic             xfer;
   logic             enc_in;
   logic             tail_last;
   logic             tag_valid;
   logic             tag_sof;
   logic             tag_tail;
   logic             tag_eof;
   logic             tag_abort;
   logic             m_valid;
   logic             m_sof;
   logic             m_tail;
   logic             m_eof;
   logic             m_abort;
   logic [GAP_W-1:0] gap;
   logic             permit;
   logic             grant;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] err_cnt;

   // State register; reset re-enters FLUSH because the encoder itself has no reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= FLUSH;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: flush, wait for bit 0, take payload (or underrun), then tail.
   always_comb begin
      state_next = state;
      case (state)
         FLUSH: begin
            if (cnt == FLUSH_LAST) state_next = IDLE;
         end
         IDLE: begin
            if (bus.s_valid) state_next = (FRAME_LEN == 1) ? TAIL : PAYLOAD;
         end
         PAYLOAD: begin
            if (!bus.s_valid || cnt == PAY_LAST) state_next = TAIL;
         end
         TAIL: begin
            if (cnt == TAIL_LAST) state_next = IDLE;
         end
         default: state_next = FLUSH;
      endcase
   end

   // Output logic: handshake, encoder drive and the per-bit tags that get registered.
   always_comb begin
      s_ready   = (state == IDLE) || (state == PAYLOAD);
      xfer      = s_ready & bus.s_valid;
      enc_in    = xfer & bus.s_data;
      tail_last = (state == TAIL) && (cnt == TAIL_LAST);
      tag_valid = xfer || (state == TAIL);
      tag_sof   = xfer && (state == IDLE);
      tag_tail  = (state == TAIL);
      tag_eof   = tail_last;
      tag_abort = tail_last & abort;
   end

   // Bit/flush/tail counter, underrun flag and completed-frame counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         abort     <= 1'b0;
         frame_cnt <= '0;
      end else begin
         if (state_next != state) begin
            cnt <= (state_next == PAYLOAD) ? BIT_W'(1) : '0;
         end else if (state == FLUSH || state == TAIL || xfer) begin
            cnt <= cnt + BIT_W'(1);
         end
         if (state == PAYLOAD && !bus.s_valid) begin
            abort <= 1'b1;
         end else if (tail_last) begin
            abort <= 1'b0;
         end
         if (tail_last) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
      end
   end

   // Tags delayed one cycle so they line up with the encoder's registered symbols.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         m_valid <= 1'b0;
         m_sof   <= 1'b0;
         m_tail  <= 1'b0;
         m_eof   <= 1'b0;
         m_abort <= 1'b0;
      end else begin
         m_valid <= tag_valid;
         m_sof   <= tag_sof;
         m_tail  <= tag_tail;
         m_eof   <= tag_eof;
         m_abort <= tag_abort;
      end
   end

   // Noise permission: only payload symbols outside the spacing window get an error.
   always_comb begin
      permit = m_valid & ~m_tail & (gap == '0);
      grant  = bus.noise_req & permit;
   end

   // Spacing window and granted-error counter; requests that are not granted are dropped.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gap     <= '0;
         err_cnt <= '0;
      end else if (grant) begin
         gap     <= GAP_W'(MIN_GAP);
         err_cnt <= err_cnt + CNT_W'(1);
      end else if (gap != '0) begin
         gap <= gap - GAP_W'(1);
      end
   end

   assign bus.s_ready   = s_ready;
   assign bus.enc_in    = enc_in;
   assign bus.m_valid   = m_valid;
   assign bus.m_out1    = bus.enc_out1;
   assign bus.m_out2    = bus.enc_out2;
   assign bus.m_sof     = m_sof;
   assign bus.m_tail    = m_tail;
   assign bus.m_eof     = m_eof;
   assign bus.m_abort   = m_abort;
   assign bus.noise0    = bus.noise_sel_req;
   assign bus.noise1    = ~grant;
   assign bus.busy      = (state != IDLE);
   assign bus.frame_cnt = frame_cnt;
   assign bus.err_cnt   = err_cnt;
endmodule

// File: tb/tb_cc4_frame_sequencer.sv
// Self-checking bench for cc4_frame_sequencer: a directed vector table for
// reset release, an underrun frame and noise gating, then hand-written
// sequences for continuous streaming with an impulse frame and a mid-frame reset.
module tb_cc4_frame_sequencer;
   localparam int FRAME_LEN = 16;
   localparam int TAIL_LEN  = 3;
   localparam int MIN_GAP   = 8;
   localparam int CNT_W     = 8;

   typedef struct {
      logic       sv;
      logic       sd;
      logic       nr;
      logic       ns;
      logic [9:0] flags;
      logic [7:0] frames;
      logic [7:0] errs;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   int         checks = 0;
   int         failures = 0;
   logic [2:0] enc_state = 3'b101;
   logic       enc_o1 = 1'b1;
   logic       enc_o2 = 1'b0;
   vec_t       vecs[15];

   cc4_frame_sequencer_if #(.CNT_W(CNT_W)) bus_if ();

   cc4_frame_sequencer #(
      .FRAME_LEN(FRAME_LEN),
      .TAIL_LEN (TAIL_LEN),
      .MIN_GAP  (MIN_GAP),
      .CNT_W    (CNT_W)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus_if)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // Behavioural K=4 encoder with generators 1111/1011; no reset, starts with junk state.
   always @(posedge clock) begin
      enc_o1    <= bus_if.enc_in ^ enc_state[0] ^ enc_state[1] ^ enc_state[2];
      enc_o2    <= bus_if.enc_in ^ enc_state[1] ^ enc_state[2];
      enc_state <= {enc_state[1:0], bus_if.enc_in};
   end

   assign bus_if.enc_out1 = enc_o1;
   assign bus_if.enc_out2 = enc_o2;

   // Order: s_ready enc_in m_valid m_sof m_tail m_eof m_abort noise0 noise1 busy
   function automatic logic [9:0] flags_now();
      return {bus_if.s_ready, bus_if.enc_in, bus_if.m_valid, bus_if.m_sof,
              bus_if.m_tail, bus_if.m_eof, bus_if.m_abort, bus_if.noise0,
              bus_if.noise1, bus_if.busy};
   endfunction

   function automatic vec_t mk(input logic sv, input logic sd, input logic nr,
                               input logic ns, input logic [9:0] flags,
                               input logic [7:0] frames, input logic [7:0] errs);
      vec_t v;
      v.sv = sv; v.sd = sd; v.nr = nr; v.ns = ns;
      v.flags = flags; v.frames = frames; v.errs = errs;
      return v;
   endfunction

   task automatic apply_stimulus(input logic sv, input logic sd, input logic nr, input logic ns);
      bus_if.s_valid       = sv;
      bus_if.s_data        = sd;
      bus_if.noise_req     = nr;
      bus_if.noise_sel_req = ns;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Main directed sequence.
   initial begin
      int         p_in;
      int         p;
      logic       d;
      logic [9:0] exp_flags;
      logic [1:0] exp_sym;

      // Reset release, 4 flush cycles, bit 0..4, underrun at bit 5, tail, idle.
      vecs[0]  = mk(1, 1, 1, 0, 10'b0000000011, 0, 0);
      vecs[1]  = mk(1, 1, 1, 1, 10'b0000000111, 0, 0);
      vecs[2]  = mk(1, 0, 1, 0, 10'b0000000011, 0, 0);
      vecs[3]  = mk(1, 1, 1, 0, 10'b0000000011, 0, 0);
      vecs[4]  = mk(1, 1, 1, 0, 10'b1100000010, 0, 0);
      vecs[5]  = mk(1, 0, 1, 1, 10'b1011000101, 0, 0);
      vecs[6]  = mk(1, 1, 1, 0, 10'b1110000011, 0, 1);
      vecs[7]  = mk(1, 1, 0, 0, 10'b1110000011, 0, 1);
      vecs[8]  = mk(1, 0, 0, 0, 10'b1010000011, 0, 1);
      vecs[9]  = mk(0, 1, 0, 1, 10'b1010000111, 0, 1);
      vecs[10] = mk(1, 1, 0, 0, 10'b0000000011, 0, 1);
      vecs[11] = mk(1, 1, 0, 0, 10'b0010100011, 0, 1);
      vecs[12] = mk(1, 1, 0, 0, 10'b0010100011, 0, 1);
      vecs[13] = mk(0, 0, 0, 0, 10'b1010111010, 1, 1);
      vecs[14] = mk(0, 0, 1, 1, 10'b1000000110, 1, 1);

      apply_stimulus(1, 1, 1, 0);
      @(negedge clock);
      @(negedge clock);
      #1;
      check_output("reset state", {flags_now(), bus_if.frame_cnt, bus_if.err_cnt},
                   {10'b0000000011, 8'd0, 8'd0});

      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         apply_stimulus(vecs[i].sv, vecs[i].sd, vecs[i].nr, vecs[i].ns);
         #1;
         check_output($sformatf("vec%0d", i),
                      {flags_now(), bus_if.frame_cnt, bus_if.err_cnt},
                      {vecs[i].flags, vecs[i].frames, vecs[i].errs});
         @(negedge clock);
      end

      // Three back-to-back frames; frame 0 is an impulse (only bit 15 set) with noise held.
      for (int t = 0; t < 58; t++) begin
         p_in = t % 19;
         d    = (t == 15) || (t >= 19 && (t % 3 == 0));
         apply_stimulus(t < 57, d, t < 20, 1'b0);
         #1;
         exp_flags = '0;
         exp_flags[9] = (p_in <= 15);
         exp_flags[8] = (t < 57 && p_in <= 15) ? d : 1'b0;
         if (t > 0) begin
            p = (t - 1) % 19;
            exp_flags[7] = 1'b1;
            exp_flags[6] = (p == 0);
            exp_flags[5] = (p >= 16);
            exp_flags[4] = (p == 18);
         end
         exp_flags[1] = !(t == 1 || t == 10);
         exp_flags[0] = (p_in != 0);
         check_output($sformatf("stream t=%0d", t), flags_now(), exp_flags);
         if (t >= 1 && t <= 19) begin
            case (t - 1)
               15:      exp_sym = 2'b11;
               16:      exp_sym = 2'b10;
               17:      exp_sym = 2'b11;
               18:      exp_sym = 2'b11;
               default: exp_sym = 2'b00;
            endcase
            check_output($sformatf("impulse sym%0d", t - 1),
                         {bus_if.m_out1, bus_if.m_out2}, exp_sym);
         end
         @(negedge clock);
      end
      apply_stimulus(0, 0, 0, 0);
      #1;
      check_output("frame_cnt after stream", bus_if.frame_cnt, 8'd4);
      check_output("err_cnt after stream", bus_if.err_cnt, 8'd3);

      // Mid-frame reset at payload bit 10.
      @(negedge clock);
      for (int u = 0; u < 10; u++) begin
         apply_stimulus(1, 1, 0, 0);
         @(negedge clock);
      end
      apply_stimulus(1, 1, 1, 0);
      #1;
      check_output("pre-reset flags", flags_now(), 10'b1110000001);
      #1;
      reset = 1'b1;
      #1;
      check_output("reset mid-frame", {flags_now(), bus_if.frame_cnt, bus_if.err_cnt},
                   {10'b0000000011, 8'd0, 8'd0});
      @(negedge clock);
      reset = 1'b0;
      apply_stimulus(1, 1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         #1;
         check_output($sformatf("reflush k=%0d", k),
                      {bus_if.s_ready, bus_if.enc_in, bus_if.m_valid, bus_if.m_eof, bus_if.busy},
                      {k == 4, k == 4, 1'b0, 1'b0, k != 4});
         @(negedge clock);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
